// File: rtl/maze_pkg.sv
// Shared definitions for the maze game controller: FSM encodings,
// move-pulse bit positions and default geometry/timing parameters.
package maze_pkg;

  typedef enum logic [2:0] {
    ST_MENU     = 3'd0,
    ST_SHOW_MAP = 3'd1,
    ST_PLAYING  = 3'd2,
    ST_FETCH    = 3'd3,
    ST_CHECK    = 3'd4,
    ST_LOST     = 3'd5,
    ST_WON      = 3'd6
  } state_e;

  localparam int MV_UP    = 3;
  localparam int MV_DOWN  = 2;
  localparam int MV_LEFT  = 1;
  localparam int MV_RIGHT = 0;

  localparam int DEF_MAP_W       = 30;
  localparam int DEF_MAP_H       = 21;
  localparam int DEF_SHOW_CYCLES = 1000000;
  localparam int DEF_LIVES       = 3;

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Player-input, map-ROM and status signals of the maze game controller.
// The controller connects through the slave modport.
interface maze_game_ctrl_if import maze_pkg::*; #(
  parameter int MAP_W = DEF_MAP_W,
  parameter int MAP_H = DEF_MAP_H
) ();
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);

  logic             start;
  logic [3:0]       move_en;
  logic [YW-1:0]    rom_addr;
  logic [MAP_W-1:0] rom_data;
  logic [XW-1:0]    player_x;
  logic [YW-1:0]    player_y;
  logic [2:0]       state;
  logic             map_visible;
  logic             lost;
  logic             won;
  logic [2:0]       lives_left;

  modport master (
    output start, move_en, rom_data,
    input  rom_addr, player_x, player_y, state, map_visible, lost, won, lives_left
  );

  modport slave (
    input  start, move_en, rom_data,
    output rom_addr, player_x, player_y, state, map_visible, lost, won, lives_left
  );
endinterface

// File: rtl/maze_show_timer.sv
// Counts cycles while the map is on screen; done flags the last show cycle.
module maze_show_timer #(
  parameter int SHOW_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int TW = $clog2(SHOW_CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == TW'(SHOW_CYCLES - 1));

  // Wraps to zero on done so the counter can never overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (en)   cnt_d = done ? '0 : cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game controller: shows the map, then walks the player one cell per
// accepted move, checking each target cell against an external map ROM.
module maze_game_ctrl import maze_pkg::*; #(
  parameter int MAP_W       = DEF_MAP_W,
  parameter int MAP_H       = DEF_MAP_H,
  parameter int SHOW_CYCLES = DEF_SHOW_CYCLES,
  parameter int LIVES       = DEF_LIVES,
  parameter int START_X     = 0,
  parameter int START_Y     = MAP_H - 1,
  parameter int GOAL_X      = MAP_W - 1,
  parameter int GOAL_Y      = 0
) (
  input  logic            clk,
  input  logic            Reset,
  maze_game_ctrl_if.slave bus
);
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);

  logic [1:0] rst_sync_q;
  logic       rst_i;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_i = rst_sync_q[1];

  state_e        state_q, state_d;
  logic [XW-1:0] px_q, px_d, cx_q, cx_d, nx;
  logic [YW-1:0] py_q, py_d, cy_q, cy_d, ny, rom_addr_q, rom_addr_d;
  logic [2:0]    lives_q, lives_d;
  logic          mv_ok, tmr_done;

  maze_show_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst_i),
    .clr  (state_q != ST_SHOW_MAP),
    .en   (state_q == ST_SHOW_MAP),
    .done (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    lives_d    = lives_q;
    rom_addr_d = rom_addr_q;
    mv_ok      = 1'b0;
    nx         = px_q;
    ny         = py_q;

    // Only a single set bit is a move; edges of the maze block the candidate.
    case (bus.move_en)
      4'b1 << MV_UP:    if (py_q != '0)               begin mv_ok = 1'b1; ny = py_q - YW'(1); end
      4'b1 << MV_DOWN:  if (py_q != YW'(MAP_H - 1))   begin mv_ok = 1'b1; ny = py_q + YW'(1); end
      4'b1 << MV_LEFT:  if (px_q != '0)               begin mv_ok = 1'b1; nx = px_q - XW'(1); end
      4'b1 << MV_RIGHT: if (px_q != XW'(MAP_W - 1))   begin mv_ok = 1'b1; nx = px_q + XW'(1); end
      default: ;
    endcase

    case (state_q)
      ST_MENU: begin
        if (bus.start) begin
          state_d = ST_SHOW_MAP;
          px_d    = XW'(START_X);
          py_d    = YW'(START_Y);
          lives_d = 3'(LIVES);
        end
      end
      ST_SHOW_MAP: if (tmr_done) state_d = ST_PLAYING;
      ST_PLAYING: begin
        if (mv_ok) begin
          cx_d       = nx;
          cy_d       = ny;
          rom_addr_d = ny;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: begin
        if (!bus.rom_data[cx_q]) begin
          px_d    = cx_q;
          py_d    = cy_q;
          state_d = (cx_q == XW'(GOAL_X) && cy_q == YW'(GOAL_Y)) ? ST_WON : ST_PLAYING;
        end else if (lives_q == 3'd1) begin
          lives_d = 3'd0;
          state_d = ST_LOST;
        end else begin
          lives_d = lives_q - 3'd1;
          px_d    = XW'(START_X);
          py_d    = YW'(START_Y);
          state_d = ST_SHOW_MAP;
        end
      end
      ST_LOST, ST_WON: begin
        if (bus.start) begin
          state_d = ST_MENU;
          px_d    = XW'(START_X);
          py_d    = YW'(START_Y);
          lives_d = 3'(LIVES);
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_MENU;
      px_q       <= XW'(START_X);
      py_q       <= YW'(START_Y);
      cx_q       <= XW'(START_X);
      cy_q       <= YW'(START_Y);
      lives_q    <= 3'(LIVES);
      rom_addr_q <= YW'(START_Y);
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      lives_q    <= lives_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.player_x    = px_q;
  assign bus.player_y    = py_q;
  assign bus.state       = state_q;
  assign bus.lives_left  = lives_q;
  assign bus.map_visible = (state_q == ST_SHOW_MAP);
  assign bus.lost        = (state_q == ST_LOST);
  assign bus.won         = (state_q == ST_WON);
endmodule

// File: doc/maze_game_ctrl.md
MAZE_GAME_CTRL -- requirements
Module: maze_game_ctrl

Interface
REQ-001 Parameter MAP_W, default 30, maze columns (>=2).
REQ-002 Parameter MAP_H, default 21, maze rows (>=2).
REQ-003 Parameter SHOW_CYCLES, default 1000000, clk cycles the map is shown before play.
REQ-004 Parameter LIVES, default 3, wall hits allowed before loss (1..7).
REQ-005 Parameters START_X/START_Y, defaults 0/MAP_H-1; GOAL_X/GOAL_Y, defaults MAP_W-1/0.
REQ-006 clk  in  1  system clock; all state on its rising edge.
REQ-007 Reset  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  one-cycle select pulse, already debounced.
REQ-009 move_en  in  4  one-cycle move pulses {up,down,left,right}, bit3=up.
REQ-010 rom_addr  out  YW=$clog2(MAP_H)  row address to external map ROM.
REQ-011 rom_data  in  MAP_W  row contents, valid 1 cycle after rom_addr; bit x=1 means wall at column x.
REQ-012 player_x  out  XW=$clog2(MAP_W)  committed column; player_y  out  YW  committed row.
REQ-013 state  out  3  current FSM state encoding.
REQ-014 map_visible, lost, won  out  1 each  level flags; lives_left  out  3  remaining lives.

Function
REQ-015 FSM states: MENU, SHOW_MAP, PLAYING, FETCH, CHECK, LOST, WON.
REQ-016 MENU: start pulse -> SHOW_MAP; show timer cleared; player at START; lives_left=LIVES.
REQ-017 SHOW_MAP: map_visible=1; timer increments each cycle; at timer==SHOW_CYCLES-1 -> PLAYING, timer cleared.
REQ-018 PLAYING: map_visible=0; move accepted only if exactly one move_en bit set; zero or multiple bits ignored.
REQ-019 Candidate: up y-1, down y+1, left x-1, right x+1; candidate outside 0..MAP_W-1 / 0..MAP_H-1 ignored, no wrap, no state change.
REQ-020 Accepted move: candidate latched, rom_addr=candidate y, -> FETCH (1 cycle) -> CHECK; rom_data sampled in CHECK.
REQ-021 CHECK, free cell: commit candidate to player_x/y; if equal to GOAL -> WON else -> PLAYING.
REQ-022 CHECK, wall: lives_left decrements; if result 0 -> LOST, position unchanged; else player set to START, -> SHOW_MAP (map reshown).
REQ-023 move_en and start ignored in FETCH, CHECK, SHOW_MAP; no queueing.
REQ-024 LOST: lost=1; WON: won=1; both hold until start pulse -> MENU.
REQ-025 rom_addr holds its last value outside FETCH/CHECK; move latency pulse-to-committed position is 3 cycles.
REQ-026 Timer width $clog2(SHOW_CYCLES+1); no overflow; SHOW_CYCLES=1 gives a one-cycle show.

Reset
REQ-027 On Reset: state=MENU, player=(START_X,START_Y), lives_left=LIVES, timer=0, rom_addr=START_Y, map_visible/lost/won=0.
REQ-028 Reset mid-FETCH/CHECK aborts the move; pending candidate discarded; no life lost.
REQ-029 Reset is applied asynchronously and released synchronously to clk at the top level.

Structure
REQ-030 State encodings, move-bit indices and default parameter values live in shared package maze_pkg.
REQ-031 Show-map timer is sub-module maze_show_timer (clear, enable, done at SHOW_CYCLES-1).
REQ-032 ROM instance is external; this block contains no map storage.

Verification
REQ-033 Reset, start, wait SHOW_CYCLES=4 -> map_visible=1 for 4 cycles, then state=PLAYING, player=(0,20).
REQ-034 Player (0,20), move_en=0001 with rom row 20 bit1=0 -> rom_addr=20, player=(1,20) 3 cycles later.
REQ-035 Player (0,20), move_en=0010 or 0100 -> no FETCH, position unchanged; move_en=1001 -> ignored.
REQ-036 LIVES=2, two wall moves -> lives 2->1 with return to (0,20) and SHOW_MAP, then lives 0, lost=1, state=LOST.
REQ-037 Player (28,0) free move right -> player=(29,0), won=1; start -> MENU, lives=LIVES, won=0.
REQ-038 Reset asserted in FETCH -> state=MENU next edge, player=(0,20), lives unchanged at LIVES.
